// File: rtl/uart_frame_tx_pkg.sv
// Shared constants for the response-frame transmitter: state encoding, CRC-8
// polynomial, default framing bytes and a byte-serial CRC step.
package uart_frame_tx_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  localparam logic [7:0] CRC8_POLY  = 8'h07;
  localparam logic [7:0] DEF_HEADER = 8'h80;
  localparam logic [7:0] DEF_TAIL   = 8'h55;

  // MSB-first, unreflected CRC-8 update over one byte.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_tx_crc8.sv
// Byte-serial CRC-8 accumulator; clear has priority over update.
module crc8
  import uart_frame_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       crc_en,
  input  logic       crc_clr,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (crc_clr) begin
      crc_d = 8'h00;
    end else if (crc_en) begin
      crc_d = crc8_next(crc_q, data_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/uart_frame_tx.sv
// Response-frame transmitter: HEADER, payload, optional CRC-8 and TAIL handed
// to a byte-level uart_tx one byte at a time with a programmable gap.
module uart_frame_tx
  import uart_frame_tx_pkg::*;
#(
  parameter int         MAX_BYTES  = 8,
  parameter int         LEN_W      = 4,
  parameter logic [7:0] HEADER     = DEF_HEADER,
  parameter logic [7:0] TAIL       = DEF_TAIL,
  parameter bit         CRC_EN     = 1'b1,
  parameter int         GAP_CYCLES = 16
) (
  input  logic                   clk_50M,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [LEN_W-1:0]       req_len,
  input  logic [8*MAX_BYTES-1:0] req_data,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic                   req_drop,
  output logic                   uart_tx_en,
  output logic [7:0]             uart_tx_data,
  input  logic                   uart_tx_busy,
  input  logic                   uart_tx_done,
  output logic [1:0]             dbg_state
);

  // Handshake: uart_tx_en is a single-cycle start strobe, accepted only while
  // uart_tx_busy was low in the preceding ISSUE cycle; uart_tx_data is valid
  // with the strobe and held until the next one; uart_tx_done is honoured
  // only while waiting on the byte just issued.

  localparam int IDX_W = $clog2(MAX_BYTES + 4);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       len_q, len_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   tx_en_q, tx_en_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   done_q, done_d;
  logic                   drop_q, drop_d;

  logic                   crc_en;
  logic                   crc_clr;
  logic [7:0]             crc_out;
  logic [7:0]             pay_byte;
  logic [7:0]             cur_byte;
  logic                   is_payload;
  logic [IDX_W-1:0]       last_idx;
  logic [IDX_W-1:0]       len_clamp;

  assign len_clamp = (req_len > LEN_W'(MAX_BYTES)) ? IDX_W'(MAX_BYTES) : IDX_W'(req_len);

  // Frame byte at the current index: 0 = HEADER, 1..L = payload, then CRC, then TAIL.
  always_comb begin
    pay_byte = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (idx_q == IDX_W'(i + 1)) begin
        pay_byte = data_q[8*i +: 8];
      end
    end
    last_idx   = len_q + (CRC_EN ? IDX_W'(2) : IDX_W'(1));
    is_payload = (idx_q != '0) && (idx_q <= len_q);
    if (idx_q == '0) begin
      cur_byte = HEADER;
    end else if (is_payload) begin
      cur_byte = pay_byte;
    end else if (CRC_EN && (idx_q == len_q + IDX_W'(1))) begin
      cur_byte = crc_out;
    end else begin
      cur_byte = TAIL;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    data_d    = data_q;
    gap_d     = gap_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    crc_en    = 1'b0;
    crc_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          data_d  = req_data;
          len_d   = len_clamp;
          idx_d   = '0;
          crc_clr = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!uart_tx_busy) begin
          tx_data_d = cur_byte;
          tx_en_d   = 1'b1;
          crc_en    = is_payload;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (uart_tx_done) begin
          if (idx_q == last_idx) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? ST_ISSUE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_ISSUE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (req && (state_q != ST_IDLE)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      gap_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      data_q    <= data_d;
      gap_q     <= gap_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  crc8 u_crc8 (
    .clk     (clk_50M),
    .rst_n   (rst_n),
    .crc_en  (crc_en),
    .crc_clr (crc_clr),
    .data_in (cur_byte),
    .crc_out (crc_out)
  );

  assign frame_busy   = (state_q != ST_IDLE);
  assign frame_done   = done_q;
  assign req_drop     = drop_q;
  assign uart_tx_en   = tx_en_q;
  assign uart_tx_data = tx_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: two instances (CRC on with a 16-cycle gap, CRC off
// with no gap), a byte-queue frame model and a per-cycle output compare.
module tb_uart_frame_tx;

  localparam int MAXB         = 8;
  localparam int LW           = 4;
  localparam int GAP0         = 16;
  localparam int GAP1         = 0;
  localparam int FRAME_BUDGET = 3000;

  // ---------------- clock / reset ----------------
  logic clk_50M;
  logic rst_n;
  int   cyc;

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc++;

  // ---------------- DUT signals ----------------
  logic            req        [2];
  logic [LW-1:0]   req_len    [2];
  logic [8*MAXB-1:0] req_data [2];
  logic            frame_busy [2];
  logic            frame_done [2];
  logic            req_drop   [2];
  logic            tx_en      [2];
  logic [7:0]      tx_data    [2];
  logic            tx_busy    [2];
  logic            tx_done    [2];
  logic [1:0]      dbg_state  [2];

  logic            rsp_busy   [2];
  logic            rsp_done   [2];
  logic            hold_busy  [2];
  logic            spur_done  [2];
  int              rsp_cnt    [2];
  bit              rand_on;

  assign tx_busy[0] = rsp_busy[0] | hold_busy[0];
  assign tx_busy[1] = rsp_busy[1] | hold_busy[1];
  assign tx_done[0] = rsp_done[0] | spur_done[0];
  assign tx_done[1] = rsp_done[1] | spur_done[1];

  uart_frame_tx #(
    .MAX_BYTES(MAXB), .LEN_W(LW), .HEADER(8'h80), .TAIL(8'h55),
    .CRC_EN(1'b1), .GAP_CYCLES(GAP0)
  ) dut0 (
    .clk_50M(clk_50M), .rst_n(rst_n), .req(req[0]), .req_len(req_len[0]),
    .req_data(req_data[0]), .frame_busy(frame_busy[0]), .frame_done(frame_done[0]),
    .req_drop(req_drop[0]), .uart_tx_en(tx_en[0]), .uart_tx_data(tx_data[0]),
    .uart_tx_busy(tx_busy[0]), .uart_tx_done(tx_done[0]), .dbg_state(dbg_state[0])
  );

  uart_frame_tx #(
    .MAX_BYTES(MAXB), .LEN_W(LW), .HEADER(8'h80), .TAIL(8'h55),
    .CRC_EN(1'b0), .GAP_CYCLES(GAP1)
  ) dut1 (
    .clk_50M(clk_50M), .rst_n(rst_n), .req(req[1]), .req_len(req_len[1]),
    .req_data(req_data[1]), .frame_busy(frame_busy[1]), .frame_done(frame_done[1]),
    .req_drop(req_drop[1]), .uart_tx_en(tx_en[1]), .uart_tx_data(tx_data[1]),
    .uart_tx_busy(tx_busy[1]), .uart_tx_done(tx_done[1]), .dbg_state(dbg_state[1])
  );

  // Byte-level uart stand-in: busy from the start strobe, done after 2..6 cycles.
  always @(posedge clk_50M) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      rsp_done[k] = 1'b0;
      if (!rst_n) begin
        rsp_cnt[k]  = 0;
        rsp_busy[k] = 1'b0;
      end else if (tx_en[k]) begin
        rsp_busy[k] = 1'b1;
        rsp_cnt[k]  = $urandom_range(2, 6);
      end else if (rsp_cnt[k] > 0) begin
        rsp_cnt[k]--;
        if (rsp_cnt[k] == 0) begin
          rsp_busy[k] = 1'b0;
          rsp_done[k] = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;

  task automatic chk(input int k, input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got %02h expected %02h", nm, k, cyc, act, exp);
    end
  endtask

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] act_log0 [$];
  logic [7:0] act_log1 [$];
  int         sp_log0 [$];
  int         sp_log1 [$];

  bit         m_busy [2];
  bit         m_wait [2];
  bit         m_done_p [2];
  bit         m_drop_p [2];
  bit         m_en_p [2];
  logic [7:0] m_data [2];
  int         m_issue [2];
  int         acc_cyc [2];
  int         acc_done [2];
  int         first_en [2];
  bit         first_pend [2];
  int         done_cnt [2];
  int         drop_cnt [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? GAP0 : GAP1;
  endfunction

  // CRC-8 as polynomial long division of (crc ^ byte) * x^8 by 0x107.
  function automatic logic [7:0] ref_crc(input logic [7:0] crc, input logic [7:0] b);
    logic [15:0] r;
    logic [15:0] p;
    r = {crc ^ b, 8'h00};
    for (int i = 15; i >= 8; i--) begin
      p = 16'h0107 << (i - 8);
      if (r[i]) r = r ^ p;
    end
    return r[7:0];
  endfunction

  function automatic void push_exp(input int k, input logic [7:0] b);
    if (k == 0) exp_q0.push_back(b);
    else exp_q1.push_back(b);
  endfunction

  function automatic logic [7:0] pop_exp(input int k);
    if (k == 0) return (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
    return (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'hxx;
  endfunction

  function automatic int exp_left(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic int log_size(input int k);
    return (k == 0) ? act_log0.size() : act_log1.size();
  endfunction

  function automatic logic [7:0] log_at(input int k, input int j);
    return (k == 0) ? act_log0[j] : act_log1[j];
  endfunction

  function automatic int sp_size(input int k);
    return (k == 0) ? sp_log0.size() : sp_log1.size();
  endfunction

  function automatic int sp_at(input int k, input int j);
    return (k == 0) ? sp_log0[j] : sp_log1[j];
  endfunction

  function automatic void build_frame(input int k);
    int                l;
    logic [8*MAXB-1:0] d;
    logic [7:0]        c;
    logic [7:0]        b;
    l = (int'(req_len[k]) > MAXB) ? MAXB : int'(req_len[k]);
    d = req_data[k];
    c = 8'h00;
    push_exp(k, 8'h80);
    for (int i = 0; i < l; i++) begin
      b = d[8*i +: 8];
      c = ref_crc(c, b);
      push_exp(k, b);
    end
    if (k == 0) push_exp(k, c);
    push_exp(k, 8'h55);
  endfunction

  function automatic void model_reset(input int k);
    m_busy[k] = 0; m_wait[k] = 0; m_done_p[k] = 0; m_drop_p[k] = 0;
    m_en_p[k] = 0; m_data[k] = 8'h00; first_pend[k] = 0;
    if (k == 0) exp_q0.delete();
    else exp_q1.delete();
  endfunction

  // Advance the frame model by one cycle using this cycle's inputs.
  function automatic void model_step(input int k);
    m_done_p[k] = 0; m_drop_p[k] = 0; m_en_p[k] = 0;
    if (m_busy[k]) begin
      if (req[k]) m_drop_p[k] = 1;
      if (m_wait[k]) begin
        if (tx_done[k]) begin
          m_wait[k]   = 0;
          acc_done[k] = cyc;
          if (exp_left(k) == 0) begin
            m_done_p[k] = 1;
            m_busy[k]   = 0;
          end else begin
            m_issue[k] = cyc + gap_of(k) + 1;
          end
        end
      end else if (cyc >= m_issue[k] && !tx_busy[k]) begin
        m_en_p[k] = 1;
        m_data[k] = pop_exp(k);
        m_wait[k] = 1;
      end
    end else if (req[k]) begin
      build_frame(k);
      m_busy[k]     = 1;
      m_wait[k]     = 0;
      m_issue[k]    = cyc + 1;
      acc_cyc[k]    = cyc;
      first_pend[k] = 1;
    end
  endfunction

  // Single compare process: outputs of this cycle against the model, then step.
  always @(negedge clk_50M) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      chk(k, "frame_busy",   {7'b0, frame_busy[k]}, {7'b0, m_busy[k]});
      chk(k, "frame_done",   {7'b0, frame_done[k]}, {7'b0, m_done_p[k]});
      chk(k, "req_drop",     {7'b0, req_drop[k]},   {7'b0, m_drop_p[k]});
      chk(k, "uart_tx_en",   {7'b0, tx_en[k]},      {7'b0, m_en_p[k]});
      chk(k, "uart_tx_data", tx_data[k], m_data[k]);
      if (tx_en[k]) begin
        if (k == 0) act_log0.push_back(tx_data[k]);
        else act_log1.push_back(tx_data[k]);
        if (first_pend[k]) begin
          first_en[k]   = cyc;
          first_pend[k] = 0;
        end else if (k == 0) begin
          sp_log0.push_back(cyc - acc_done[k]);
        end else begin
          sp_log1.push_back(cyc - acc_done[k]);
        end
      end
      if (frame_done[k]) done_cnt[k]++;
      if (req_drop[k]) drop_cnt[k]++;
      if (rst_n) model_step(k);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((frame_busy[k] || m_busy[k]) && n < FRAME_BUDGET) begin
      if (rand_on) begin
        hold_busy[k] = ($urandom_range(0, 7) == 0);
        spur_done[k] = !m_wait[k] && ($urandom_range(0, 15) == 0);
        req[k]       = ($urandom_range(0, 31) == 0);
      end
      tick();
      n++;
    end
    req[k] = 1'b0; hold_busy[k] = 1'b0; spur_done[k] = 1'b0;
    checks++;
    if (n >= FRAME_BUDGET) begin
      errors++;
      $display("FAIL frame_timeout[%0d] cycle %0d: busy after %0d cycles, required idle", k, cyc, n);
    end
    repeat (3) tick();
  endtask

  task automatic run_frame(input int k, input int len, input logic [8*MAXB-1:0] data);
    req_len[k]  = LW'(len);
    req_data[k] = data;
    req[k]      = 1'b1;
    tick();
    req[k] = 1'b0;
    wait_idle(k);
  endtask

  task automatic expect_log(input int k, input int base, input int n, input logic [8*18-1:0] bytes);
    chk(k, "frame_len", 8'(log_size(k) - base), 8'(n));
    for (int j = 0; j < n && base + j < log_size(k); j++) begin
      chk(k, "frame_byte", log_at(k, base + j), bytes[8*(n-1-j) +: 8]);
    end
  endtask

  // ---------------- stimulus ----------------
  int lb, sb, db, dr, n;

  initial begin
    rst_n = 1'b0;
    rand_on = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; req_len[k] = '0; req_data[k] = '0;
      hold_busy[k] = 1'b0; spur_done[k] = 1'b0;
    end
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_state", {6'b0, dbg_state[k]}, 8'h00);
      chk(k, "rst_data", tx_data[k], 8'h00);
      chk(k, "rst_busy", {7'b0, frame_busy[k]}, 8'h00);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    // 3-byte frame with CRC and 16-cycle gap
    lb = log_size(0); sb = sp_size(0); db = done_cnt[0];
    run_frame(0, 3, 64'h0000_0000_0003_0201);
    expect_log(0, lb, 6, {8'h80, 8'h01, 8'h02, 8'h03, 8'h48, 8'h55});
    chk(0, "gap_count", 8'(sp_size(0) - sb), 8'd5);
    for (int j = sb; j < sp_size(0); j++) chk(0, "gap_cycles", 8'(sp_at(0, j)), 8'd18);
    chk(0, "done_count", 8'(done_cnt[0] - db), 8'd1);

    // empty payload with CRC
    lb = log_size(0);
    run_frame(0, 0, 64'h0);
    expect_log(0, lb, 3, {8'h80, 8'h00, 8'h55});

    // no CRC, no gap
    lb = log_size(1); sb = sp_size(1);
    run_frame(1, 2, 64'h0000_0000_0000_BBAA);
    expect_log(1, lb, 4, {8'h80, 8'hAA, 8'hBB, 8'h55});
    for (int j = sb; j < sp_size(1); j++) chk(1, "gap_cycles0", 8'(sp_at(1, j)), 8'd2);

    // length clamp: 12 requested, 8 sent
    lb = log_size(0);
    run_frame(0, 12, 64'h8877_6655_4433_2211);
    chk(0, "clamp_len", 8'(log_size(0) - lb), 8'd11);
    chk(0, "clamp_last_payload", log_at(0, lb + 8), 8'h88);

    // mid-frame request is dropped, frame unchanged
    lb = log_size(0); dr = drop_cnt[0];
    req_len[0] = 4'd4; req_data[0] = 64'h0000_0000_0403_0201; req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    repeat (20) tick();
    req_len[0] = 4'd7; req_data[0] = 64'hDEAD_BEEF_CAFE_F00D; req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    wait_idle(0);
    chk(0, "drop_count", 8'(drop_cnt[0] - dr), 8'd1);
    chk(0, "drop_len", 8'(log_size(0) - lb), 8'd7);
    for (int j = 1; j <= 4; j++) chk(0, "drop_payload", log_at(0, lb + j), 8'(j));

    // uart busy held for 40 cycles right after acceptance
    lb = log_size(0);
    req_len[0] = 4'd1; req_data[0] = 64'h5A; req[0] = 1'b1;
    tick();
    req[0] = 1'b0; hold_busy[0] = 1'b1;
    repeat (40) tick();
    hold_busy[0] = 1'b0;
    wait_idle(0);
    chk(0, "busy_delay", 8'(first_en[0] - acc_cyc[0]), 8'd42);
    expect_log(0, lb, 4, {8'h80, 8'h5A, ref_crc(8'h00, 8'h5A), 8'h55});

    // back-to-back: req held through completion is dropped then accepted at t+1
    lb = log_size(1); db = done_cnt[1];
    req_len[1] = 4'd1; req_data[1] = 64'h11; req[1] = 1'b1;
    n = 0;
    tick();
    while (!frame_done[1] && n < FRAME_BUDGET) begin tick(); n++; end
    tick();
    req[1] = 1'b0;
    wait_idle(1);
    chk(1, "b2b_done", 8'(done_cnt[1] - db), 8'd2);
    expect_log(1, lb, 6, {8'h80, 8'h11, 8'h55, 8'h80, 8'h11, 8'h55});

    // reset during payload byte 2 aborts the frame
    lb = log_size(0); db = done_cnt[0];
    req_len[0] = 4'd5; req_data[0] = 64'h0000_00A5_A4A3_A2A1; req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    n = 0;
    while (log_size(0) - lb < 3 && n < 1000) begin tick(); n++; end
    chk(0, "reach_byte2", 8'(log_size(0) - lb), 8'd3);
    @(posedge clk_50M);
    #3 rst_n = 1'b0;
    #1;
    chk(0, "arst_busy", {7'b0, frame_busy[0]}, 8'h00);
    chk(0, "arst_en",   {7'b0, tx_en[0]}, 8'h00);
    chk(0, "arst_data", tx_data[0], 8'h00);
    chk(0, "arst_done", {7'b0, frame_done[0]}, 8'h00);
    chk(0, "arst_drop", {7'b0, req_drop[0]}, 8'h00);
    chk(0, "arst_state", {6'b0, dbg_state[0]}, 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk(0, "abort_no_done", 8'(done_cnt[0] - db), 8'd0);
    chk(0, "abort_no_tail", 8'(log_size(0) - lb), 8'd3);
    lb = log_size(0);
    run_frame(0, 3, 64'h0000_0000_0003_0201);
    expect_log(0, lb, 6, {8'h80, 8'h01, 8'h02, 8'h03, 8'h48, 8'h55});

    // randomized frames with stalls, spurious done pulses and dropped requests
    rand_on = 1'b1;
    repeat (24) begin
      run_frame($urandom_range(0, 1), $urandom_range(0, 15), {$urandom, $urandom});
    end
    rand_on = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised response-frame transmitter between the protocol layer and the byte-level `uart_tx`. It accepts a request carrying up to MAX_BYTES payload bytes and a length, and captures them. It then emits HEADER, the payload bytes in order, an optional CRC-8 and TAIL through the `uart_tx` handshake, with a programmable inter-byte gap. It replaces fixed-length, fixed-delay response framing with an explicit request/busy/done interface.

## Interface
- MAX_BYTES, 8: payload capacity in bytes (1..15).
- LEN_W, 4: width of `req_len`; must hold MAX_BYTES.
- HEADER, 8'h80: first frame byte.
- TAIL, 8'h55: last frame byte.
- CRC_EN, 1: 1 inserts the CRC byte before TAIL; 0 omits it.
- GAP_CYCLES, 16: idle clocks between a byte's `uart_tx_done` and the next `uart_tx_en`; 0 means no gap.

Ports:
- clk_50M  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  1  frame request, sampled every cycle.
- req_len  in  LEN_W  payload byte count; values above MAX_BYTES clamp to MAX_BYTES.
- req_data  in  8*MAX_BYTES  payload; byte i is at [8i+7:8i].
- frame_busy  out  1  high from request acceptance until the frame completes.
- frame_done  out  1  one-cycle pulse at frame completion.
- req_drop  out  1  one-cycle pulse when `req` arrives while busy.
- uart_tx_en  out  1  one-cycle byte start to `uart_tx`.
- uart_tx_data  out  8  byte for `uart_tx`; registered.
- uart_tx_busy  in  1  `uart_tx` is shifting a byte.
- uart_tx_done  in  1  `uart_tx` byte-complete pulse.

## Operation
- State machine states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE, `req`=1:
  - Capture `req_data` and the clamped length.
  - Clear CRC to 0x00 and clear the byte index.
  - Go to ISSUE.
- Any other state, `req`=1: request ignored, `req_drop` pulses, captured data is unchanged.
- ISSUE, `uart_tx_busy`=0:
  - Load `uart_tx_data` with the byte at the current index.
  - Pulse `uart_tx_en` and go to WAIT_DONE.
- ISSUE, `uart_tx_busy`=1: hold in ISSUE.
- Frame byte sequence: index 0 = HEADER; 1..L = payload[0..L-1]; L+1 = CRC when CRC_EN=1; last index = TAIL. Frame length is L+2+CRC_EN.
- CRC update:
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR.
  - Updated only when a payload byte is issued. HEADER and TAIL are excluded.
- WAIT_DONE, `uart_tx_done`=1:
  - Last byte: pulse `frame_done` and go to IDLE.
  - Otherwise increment the index, then go to GAP, or to ISSUE when GAP_CYCLES=0.
- GAP: counts GAP_CYCLES clocks, then goes to ISSUE.
- L=0 is legal. The frame is HEADER, CRC 0x00 (when enabled), TAIL.

## Timing
- Reset values: state IDLE; all outputs 0; `uart_tx_data` 0x00; CRC 0x00.
- Reset asserted mid-frame aborts immediately; no TAIL and no `frame_done`.
- Request acceptance: `req` high in cycle 0 in IDLE gives `frame_busy`=1 in cycle 1. With `uart_tx_busy`=0 in cycle 1, `uart_tx_en`=1 in cycle 2.
- `uart_tx_data` is valid in the `uart_tx_en` cycle and stable until the next `uart_tx_en`.
- Inter-byte spacing: `uart_tx_done` in cycle t gives the next `uart_tx_en` in cycle t+GAP_CYCLES+2. Every ISSUE cycle stalled on `uart_tx_busy` adds 1.
- Completion: final `uart_tx_done` in cycle t gives `frame_done`=1 and `frame_busy`=0 in cycle t+1. A `req` in cycle t+1 is accepted without `req_drop`.
- `req` coinciding with the final `uart_tx_done` gives a `req_drop`.
- `uart_tx_done` outside WAIT_DONE is ignored.

## Structure
- Shared package holds the state encoding (IDLE=0, ISSUE=1, WAIT_DONE=2, GAP=3), CRC8_POLY=8'h07 and the default HEADER/TAIL constants.
- Sub-module `crc8`: the existing byte-serial CRC with `crc_en`, `crc_clr`, `data_in` and `crc_out`. This block drives `crc_clr` on acceptance and `crc_en` on payload issue.
- Byte mux over captured data, index counter and gap counter are inline.

## Test plan
- MAX_BYTES=8, GAP_CYCLES=16, L=3, data 01 02 03 -> bytes 80 01 02 03 48 55; `frame_done` once; the gap between each `uart_tx_done` and the next `uart_tx_en` is exactly 18 cycles.
- L=0, CRC_EN=1 -> 80 00 55. CRC_EN=0, L=2, data AA BB -> 80 AA BB 55.
- `req_len`=12 with MAX_BYTES=8 -> 8 payload bytes sent; total 11 bytes.
- `req` re-pulsed mid-frame with different data -> `req_drop` pulses; the transmitted frame is unchanged.
- `uart_tx_busy` held high for 40 cycles at acceptance -> first `uart_tx_en` is delayed exactly 40 cycles; no byte is lost.
- `rst_n` low during payload byte 2 -> all outputs 0 immediately; the next `req` gives a fresh frame with a correct CRC.
